temp_reg_sequencer: RTL and testbench
=====================================

// Module: temp_reg_sequencer
// PURPOSE
//  Command-driven controller for the 8-bit signed temp register (load/increment/decrement, neg/pos/zero flags).
//  Accepts one command at a time over a valid/ready handshake and issues the register's load/inc/dec strobes.
//  Sequences multi-cycle operations: N-step count, and seek-to-zero driven by the flags.
//  Sits between the processor control unit and the temp register; the control unit sees only done/status.
// PARAMETERS
//  MAX_STEPS  200  seek-to-zero step limit before timeout (1..255)
// PORTS
//  clk           in   1  clock; all state changes on rising edge
//  reset_n       in   1  synchronous, active-low reset
//  cmd_valid     in   1  command present
//  cmd_op        in   2  0=LOAD, 1=STEP_UP, 2=STEP_DOWN, 3=SEEK_ZERO
//  cmd_data      in   8  LOAD: value; STEP_*: step count N (unsigned); SEEK: ignored
//  cmd_ready     out  1  high only in IDLE (and reset_n high); accept = cmd_valid & cmd_ready
//  abort         in   1  synchronous abort of the running command
//  reg_load      out  1  load strobe to temp register
//  reg_inc       out  1  increment strobe
//  reg_dec       out  1  decrement strobe
//  reg_data      out  8  load value (latched cmd_data)
//  reg_negative  in   1  register flag, reflects current register contents
//  reg_positive  in   1  register flag
//  reg_zero      in   1  register flag
//  done          out  1  one-cycle completion pulse
//  st_neg/st_pos/st_zero out 1 each  flags captured at done; held until next done
//  timeout       out  1  seek hit MAX_STEPS; held until next done
//  aborted       out  1  command ended by abort; held until next done
//  steps_taken   out  8  strobes issued by last command; held until next done
// BEHAVIOUR
//  - Reset (reset_n low at edge): state IDLE; all outputs 0, reg_data=0x00; cmd_ready low during reset cycle.
//  - Reset mid-operation: strobes drop the cycle after the edge; no done pulse; command discarded.
//  - At most one of reg_load/reg_inc/reg_dec high in any cycle. Strobes are Moore outputs of state.
//  - States: IDLE, LOAD, STEP, SEEK, DONE. cmd_valid ignored outside IDLE (no queueing).
//  - IDLE: on accept latch op, data; clear step counter; go LOAD/STEP/SEEK per cmd_op.
//  - LOAD: reg_load=1, reg_data=latched value for exactly one cycle -> DONE. steps_taken=0.
//  - STEP: remaining=N. Each cycle remaining!=0: assert reg_inc (UP) or reg_dec (DOWN), remaining-1, steps+1.
//    remaining==0 -> DONE with no strobe that cycle. N=0: zero strobes, STEP lasts 1 cycle.
//    No saturation: register wrap 0x7F->0x80 / 0x80->0x7F is permitted and reported via flags.
//  - SEEK: each cycle sample flags (valid for current value): zero -> DONE; else if steps==MAX_STEPS -> DONE, timeout=1;
//    else positive -> reg_dec, negative -> reg_inc, steps+1. Start at zero: zero strobes.
//  - DONE: done=1 for one cycle; capture flags into st_*, set timeout/aborted/steps_taken; -> IDLE.
//  - Latency from accept edge: LOAD done 2 cycles later; STEP N: N+2; SEEK k strobes: k+2.
//  - abort in LOAD/STEP/SEEK: that cycle's strobe suppressed; -> DONE with aborted=1. Ignored in IDLE/DONE.
//  - Priority: reset_n > abort > normal sequencing.
//  - Step counter 8 bits, never wraps (N<=255, MAX_STEPS<=255).
// STRUCTURE
//  - Shared package temp_ctrl_pkg: opcode constants OP_LOAD/OP_STEP_UP/OP_STEP_DOWN/OP_SEEK_ZERO,
//    state encoding, flag index constants.
//  - One sub-module: temp_ctrl_step_counter (8-bit load/decrement counter + up-count of issued steps, zero detect).
//  - FSM, handshake and status capture stay in this module.
// TESTING  (bench instantiates a real temp register model on reg_* ports)
//  1. Reset, LOAD 0x05 -> reg_load one cycle with reg_data=0x05, done 2 cycles after accept, st_pos=1, steps_taken=0.
//  2. Then STEP_DOWN 7 -> exactly 7 consecutive reg_dec, done, st_neg=1 (reg=0xFE), steps_taken=7; STEP_UP 0 -> no strobes, done at +2.
//  3. LOAD 0xFD, SEEK_ZERO -> 3 reg_inc, st_zero=1, timeout=0; SEEK again -> 0 strobes, done at +2.
//  4. MAX_STEPS=4, LOAD 0x10, SEEK_ZERO -> 4 reg_dec, timeout=1, st_pos=1 (reg=0x0C); LOAD 0x7F, STEP_UP 1 -> st_neg=1.
//  5. STEP_UP 100, abort after 10 strobes -> no strobe in abort cycle, done next, aborted=1, steps_taken=10;
//     cmd_valid pulsed while busy -> not accepted, cmd_ready low.
//  6. reset_n low mid-STEP -> strobes/done 0 after edge, cmd_ready high after release, new LOAD accepted.

Source files
------------

// File: rtl/temp_ctrl_pkg.sv
// Shared definitions for the temp register sequencer: opcodes, FSM states and
// the bit positions used when the register flags are bundled into a vector.
package temp_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOAD      = 2'd0,
    OP_STEP_UP   = 2'd1,
    OP_STEP_DOWN = 2'd2,
    OP_SEEK_ZERO = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LOAD = 3'd1,
    ST_STEP = 3'd2,
    ST_SEEK = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int FLAG_NEG  = 0;
  localparam int FLAG_POS  = 1;
  localparam int FLAG_ZERO = 2;
  localparam int FLAG_W    = 3;

  typedef logic [FLAG_W-1:0] flags_t;

endpackage

// File: rtl/temp_ctrl_step_counter.sv
// Remaining-step down counter paired with an up-count of strobes issued.
// The down counter holds at zero so a stray step can never wrap it.
module temp_ctrl_step_counter (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       i_load,
  input  logic [7:0] i_load_value,
  input  logic       i_step,
  output logic [7:0] o_steps,
  output logic       o_rem_zero
);

  logic [7:0] r_remaining;
  logic [7:0] r_steps;

  // NOTE: reset is synchronous here, so it lives inside the clocked branch
  // and the sensitivity list carries only the clock edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_remaining <= '0;
      r_steps     <= '0;
    end else if (i_load) begin
      r_remaining <= i_load_value;
      r_steps     <= '0;
    end else if (i_step) begin
      if (r_remaining != '0) r_remaining <= r_remaining - 8'd1;
      r_steps <= r_steps + 8'd1;
    end
  end

  assign o_steps    = r_steps;
  assign o_rem_zero = (r_remaining == '0);

endmodule

// File: rtl/temp_reg_sequencer.sv
// Command sequencer for the 8-bit signed temp register: accepts one command
// over valid/ready, drives load/inc/dec strobes and reports status at done.
module temp_reg_sequencer
  import temp_ctrl_pkg::*;
#(
  parameter int unsigned MAX_STEPS = 200
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       abort,
  output logic       reg_load,
  output logic       reg_inc,
  output logic       reg_dec,
  output logic [7:0] reg_data,
  input  logic       reg_negative,
  input  logic       reg_positive,
  input  logic       reg_zero,
  output logic       done,
  output logic       st_neg,
  output logic       st_pos,
  output logic       st_zero,
  output logic       timeout,
  output logic       aborted,
  output logic [7:0] steps_taken
);

  localparam logic [7:0] MAX_STEPS_B = 8'(MAX_STEPS);

  state_e     r_state, w_next;
  op_e        r_op;
  logic [7:0] r_data;
  logic       r_abort_pend, r_timeout_pend;
  flags_t     r_st_flags;
  logic       r_timeout, r_aborted;
  logic [7:0] r_steps_taken;

  flags_t     w_flags;
  logic       w_accept, w_cnt_load, w_cnt_step, w_set_abort, w_set_timeout;
  logic       w_rem_zero;
  logic [7:0] w_cnt_value, w_steps;

  assign cmd_ready = reset_n & (r_state == ST_IDLE);
  assign w_accept  = cmd_valid & cmd_ready;

  always_comb begin
    w_flags            = '0;
    w_flags[FLAG_NEG]  = reg_negative;
    w_flags[FLAG_POS]  = reg_positive;
    w_flags[FLAG_ZERO] = reg_zero;
  end

  temp_ctrl_step_counter u_counter (
    .clk          (clk),
    .reset_n      (reset_n),
    .i_load       (w_cnt_load),
    .i_load_value (w_cnt_value),
    .i_step       (w_cnt_step),
    .o_steps      (w_steps),
    .o_rem_zero   (w_rem_zero)
  );

  // NOTE: every output of this block gets a default first so no path through
  // the case statement can leave a signal unassigned and infer a latch.
  always_comb begin
    w_next        = r_state;
    reg_load      = 1'b0;
    reg_inc       = 1'b0;
    reg_dec       = 1'b0;
    done          = 1'b0;
    w_cnt_load    = 1'b0;
    w_cnt_value   = '0;
    w_cnt_step    = 1'b0;
    w_set_abort   = 1'b0;
    w_set_timeout = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_cnt_load = 1'b1;
          case (op_e'(cmd_op))
            OP_LOAD:      w_next = ST_LOAD;
            OP_SEEK_ZERO: w_next = ST_SEEK;
            default: begin
              w_next      = ST_STEP;
              w_cnt_value = cmd_data;
            end
          endcase
        end
      end

      ST_LOAD: begin
        w_next = ST_DONE;
        if (abort) w_set_abort = 1'b1;
        else       reg_load    = 1'b1;
      end

      ST_STEP: begin
        if (abort) begin
          w_next      = ST_DONE;
          w_set_abort = 1'b1;
        end else if (w_rem_zero) begin
          w_next = ST_DONE;
        end else begin
          w_cnt_step = 1'b1;
          if (r_op == OP_STEP_UP) reg_inc = 1'b1;
          else                    reg_dec = 1'b1;
        end
      end

      // Flags describe the value the register holds this cycle; anything not
      // positive is stepped upward so inconsistent flags still terminate.
      ST_SEEK: begin
        if (abort) begin
          w_next      = ST_DONE;
          w_set_abort = 1'b1;
        end else if (reg_zero) begin
          w_next = ST_DONE;
        end else if (w_steps == MAX_STEPS_B) begin
          w_next        = ST_DONE;
          w_set_timeout = 1'b1;
        end else begin
          w_cnt_step = 1'b1;
          if (reg_positive) reg_dec = 1'b1;
          else              reg_inc = 1'b1;
        end
      end

      ST_DONE: begin
        done   = 1'b1;
        w_next = ST_IDLE;
      end

      default: w_next = ST_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state        <= ST_IDLE;
      r_op           <= OP_LOAD;
      r_data         <= '0;
      r_abort_pend   <= 1'b0;
      r_timeout_pend <= 1'b0;
      r_st_flags     <= '0;
      r_timeout      <= 1'b0;
      r_aborted      <= 1'b0;
      r_steps_taken  <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op           <= op_e'(cmd_op);
        r_data         <= cmd_data;
        r_abort_pend   <= 1'b0;
        r_timeout_pend <= 1'b0;
      end
      if (w_set_abort)   r_abort_pend   <= 1'b1;
      if (w_set_timeout) r_timeout_pend <= 1'b1;
      // Flags are sampled in DONE, after the last strobe has landed.
      if (r_state == ST_DONE) begin
        r_st_flags    <= w_flags;
        r_timeout     <= r_timeout_pend;
        r_aborted     <= r_abort_pend;
        r_steps_taken <= w_steps;
      end
    end
  end

  assign reg_data    = (r_state == ST_LOAD) ? r_data : 8'h00;
  assign st_neg      = r_st_flags[FLAG_NEG];
  assign st_pos      = r_st_flags[FLAG_POS];
  assign st_zero     = r_st_flags[FLAG_ZERO];
  assign timeout     = r_timeout;
  assign aborted     = r_aborted;
  assign steps_taken = r_steps_taken;

endmodule

// File: tb/tb_temp_reg_sequencer.sv
// Directed bench: a behavioural temp register on the reg_* ports, a table of
// commands with hand-computed results, and hand-written reset/abort sequences.
module tb_temp_reg_sequencer;
  import temp_ctrl_pkg::*;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       cmd_valid, abort;
  logic [1:0] cmd_op;
  logic [7:0] cmd_data;
  logic       cmd_ready, reg_load, reg_inc, reg_dec;
  logic [7:0] reg_data;
  logic       reg_negative, reg_positive, reg_zero;
  logic       done, st_neg, st_pos, st_zero, timeout, aborted;
  logic [7:0] steps_taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  temp_reg_sequencer #(.MAX_STEPS(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .cmd_valid    (cmd_valid),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cmd_ready    (cmd_ready),
    .abort        (abort),
    .reg_load     (reg_load),
    .reg_inc      (reg_inc),
    .reg_dec      (reg_dec),
    .reg_data     (reg_data),
    .reg_negative (reg_negative),
    .reg_positive (reg_positive),
    .reg_zero     (reg_zero),
    .done         (done),
    .st_neg       (st_neg),
    .st_pos       (st_pos),
    .st_zero      (st_zero),
    .timeout      (timeout),
    .aborted      (aborted),
    .steps_taken  (steps_taken)
  );

  // Behavioural temp register driven by the strobes.
  logic [7:0] r_temp;
  always_ff @(posedge clk) begin
    if (!reset_n)      r_temp <= 8'h00;
    else if (reg_load) r_temp <= reg_data;
    else if (reg_inc)  r_temp <= r_temp + 8'd1;
    else if (reg_dec)  r_temp <= r_temp - 8'd1;
  end
  assign reg_negative = r_temp[7];
  assign reg_zero     = (r_temp == 8'h00);
  assign reg_positive = !r_temp[7] && (r_temp != 8'h00);

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  localparam int K_LOAD = 0;
  localparam int K_INC  = 1;
  localparam int K_DEC  = 2;

  typedef struct {
    logic [1:0] op;
    logic [7:0] data;
    int         abort_at;   // abort once this many strobes have been seen (-1 never)
    bit         poke;       // pulse cmd_valid while busy
    int         exp_strobes;
    int         exp_kind;
    int         exp_lat;    // cycle index of done, accept edge starts cycle 1
    logic [2:0] exp_flags;  // {zero, pos, neg}
    bit         exp_to;
    bit         exp_ab;
    int         exp_steps;
    logic [7:0] exp_reg;
  } vec_t;

  function automatic vec_t mk(logic [1:0] op, logic [7:0] data, int abort_at, bit poke,
                              int str, int kind, int lat, logic [2:0] fl, bit to, bit ab,
                              int steps, logic [7:0] rg);
    vec_t v;
    v.op = op; v.data = data; v.abort_at = abort_at; v.poke = poke;
    v.exp_strobes = str; v.exp_kind = kind; v.exp_lat = lat; v.exp_flags = fl;
    v.exp_to = to; v.exp_ab = ab; v.exp_steps = steps; v.exp_reg = rg;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    int  n_ld, n_in, n_de, multi, lat, sel;
    bit  ab_given;
    n_ld = 0; n_in = 0; n_de = 0; multi = 0; lat = 0; ab_given = 0;
    @(negedge clk);
    check("ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = v.op; cmd_data = v.data;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    for (int cyc = 1; cyc <= 400; cyc++) begin
      @(negedge clk);
      cmd_valid = (v.poke && cyc == 2);
      if (v.abort_at >= 0 && !ab_given && (n_ld + n_in + n_de) == v.abort_at) begin
        abort = 1'b1; ab_given = 1'b1;
      end else begin
        abort = 1'b0;
      end
      #1;
      if (v.poke && cyc == 2) check("busy_not_ready", cmd_ready, 0);
      if (abort) check("abort_no_strobe", reg_load | reg_inc | reg_dec, 0);
      if (int'(reg_load) + int'(reg_inc) + int'(reg_dec) > 1) multi++;
      n_ld += int'(reg_load); n_in += int'(reg_inc); n_de += int'(reg_dec);
      if (done) begin
        lat = cyc;
        break;
      end
    end
    abort = 1'b0; cmd_valid = 1'b0;
    if (lat == 0) check("done_wait_expired", 0, 1);
    sel = (v.exp_kind == K_LOAD) ? n_ld : (v.exp_kind == K_INC) ? n_in : n_de;
    check("latency", lat, v.exp_lat);
    check("strobes", n_ld + n_in + n_de, v.exp_strobes);
    check("wrong_kind", n_ld + n_in + n_de - sel, 0);
    check("one_hot", multi, 0);
    @(negedge clk);
    #1;
    check("done_one_cycle", done, 0);
    check("st_zero", st_zero, v.exp_flags[2]);
    check("st_pos", st_pos, v.exp_flags[1]);
    check("st_neg", st_neg, v.exp_flags[0]);
    check("timeout", timeout, v.exp_to);
    check("aborted", aborted, v.exp_ab);
    check("steps_taken", steps_taken, v.exp_steps);
    check("reg_value", r_temp, v.exp_reg);
  endtask

  vec_t vecs[15];

  initial begin
    reset_n = 1'b0; cmd_valid = 1'b0; abort = 1'b0; cmd_op = 2'd0; cmd_data = 8'h00;

    //                op            data   ab  pk str kind    lat flags   to ab stp reg
    vecs[0]  = mk(OP_LOAD,      8'h05, -1, 0, 1,  K_LOAD, 2,  3'b010, 0, 0, 0,  8'h05);
    vecs[1]  = mk(OP_STEP_DOWN, 8'd7,  -1, 0, 7,  K_DEC,  9,  3'b001, 0, 0, 7,  8'hFE);
    vecs[2]  = mk(OP_STEP_UP,   8'd0,  -1, 0, 0,  K_INC,  2,  3'b001, 0, 0, 0,  8'hFE);
    vecs[3]  = mk(OP_LOAD,      8'hFD, -1, 0, 1,  K_LOAD, 2,  3'b001, 0, 0, 0,  8'hFD);
    vecs[4]  = mk(OP_SEEK_ZERO, 8'h5A, -1, 0, 3,  K_INC,  5,  3'b100, 0, 0, 3,  8'h00);
    vecs[5]  = mk(OP_SEEK_ZERO, 8'h00, -1, 0, 0,  K_INC,  2,  3'b100, 0, 0, 0,  8'h00);
    vecs[6]  = mk(OP_LOAD,      8'h10, -1, 0, 1,  K_LOAD, 2,  3'b010, 0, 0, 0,  8'h10);
    vecs[7]  = mk(OP_SEEK_ZERO, 8'h00, -1, 0, 4,  K_DEC,  6,  3'b010, 1, 0, 4,  8'h0C);
    vecs[8]  = mk(OP_LOAD,      8'h7F, -1, 0, 1,  K_LOAD, 2,  3'b010, 0, 0, 0,  8'h7F);
    vecs[9]  = mk(OP_STEP_UP,   8'd1,  -1, 0, 1,  K_INC,  3,  3'b001, 0, 0, 1,  8'h80);
    vecs[10] = mk(OP_STEP_DOWN, 8'd2,  -1, 0, 2,  K_DEC,  4,  3'b010, 0, 0, 2,  8'h7E);
    vecs[11] = mk(OP_LOAD,      8'h80, -1, 0, 1,  K_LOAD, 2,  3'b001, 0, 0, 0,  8'h80);
    vecs[12] = mk(OP_STEP_UP,   8'd100, 10, 1, 10, K_INC, 12, 3'b001, 0, 1, 10, 8'h8A);
    vecs[13] = mk(OP_LOAD,      8'h00, -1, 0, 1,  K_LOAD, 2,  3'b100, 0, 0, 0,  8'h00);
    vecs[14] = mk(OP_LOAD,      8'h33, 0,  0, 0,  K_LOAD, 2,  3'b100, 0, 1, 0,  8'h00);

    // Reset state: everything low, not ready while reset_n is held low.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_ready", cmd_ready, 0);
    check("rst_strobes", {reg_load, reg_inc, reg_dec}, 0);
    check("rst_reg_data", reg_data, 0);
    check("rst_done", done, 0);
    check("rst_status", {st_neg, st_pos, st_zero, timeout, aborted}, 0);
    check("rst_steps", steps_taken, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 15; i++) run_vec(vecs[i]);

    // Reset in the middle of a long STEP_UP.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = OP_STEP_UP; cmd_data = 8'd50;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("midstep_inc", reg_inc, 1);
    reset_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_strobes", {reg_load, reg_inc, reg_dec}, 0);
    check("midrst_done", done, 0);
    check("midrst_ready", cmd_ready, 0);
    check("midrst_steps", steps_taken, 0);
    reset_n = 1'b1;
    #1;
    check("postrst_ready", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("postrst_quiet", {done, reg_load, reg_inc, reg_dec}, 0);
    end
    run_vec(mk(OP_LOAD, 8'h22, -1, 0, 1, K_LOAD, 2, 3'b010, 0, 0, 0, 8'h22));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
